// File: rtl/pattern_seq_detector.sv
// Serial detector for a runtime-loadable PAT_W-bit pattern (MSB first in time).
// It supports overlapping and non-overlapping detection and keeps a saturating match count.
module pattern_seq_detector #(
  parameter int unsigned         PAT_W       = 4,
  parameter logic [PAT_W-1:0]    DEFAULT_PAT = PAT_W'(4'b1011),
  parameter int unsigned         CNT_W       = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inp_i,
  input  logic               inp_valid_i,
  input  logic               load_i,
  input  logic [PAT_W-1:0]   pattern_in_i,
  input  logic               overlap_i,
  input  logic               clear_count_i,
  output logic               out_o,
  output logic               armed_o,
  output logic [CNT_W-1:0]   match_count_o
);

  localparam int unsigned    FW      = $clog2(PAT_W + 1);
  localparam logic [FW-1:0]  FULL    = FW'(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {FILL, ARMED} state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic               out_q, out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PAT_W-1:0]   hist_n;
  logic [FW-1:0]      fill_inc;
  logic               match;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= FILL;
      pat_q   <= DEFAULT_PAT;
      hist_q  <= '0;
      fill_q  <= '0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    pat_d    = pat_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    out_d    = 1'b0;
    cnt_d    = cnt_q;
    match    = 1'b0;
    hist_n   = {hist_q[PAT_W-2:0], inp_i};
    fill_inc = (fill_q == FULL) ? FULL : fill_q + 1'b1;

    if (load_i) begin
      pat_d  = pattern_in_i;
      hist_d = '0;
      fill_d = '0;
    end else if (inp_valid_i) begin
      match = (fill_inc == FULL) && (hist_n == pat_q);
      if (match) begin
        out_d = 1'b1;
        // Non-overlapping mode discards the matched bits so a fresh pattern is required.
        if (overlap_i) begin
          hist_d = hist_n;
          fill_d = FULL;
        end else begin
          hist_d = '0;
          fill_d = '0;
        end
      end else begin
        hist_d = hist_n;
        fill_d = fill_inc;
      end
    end

    if (clear_count_i) begin
      cnt_d = '0;
    end else if (match && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end

    state_d = (fill_d == FULL) ? ARMED : FILL;
  end

  assign out_o         = out_q;
  assign armed_o       = (state_q == ARMED);
  assign match_count_o = cnt_q;

endmodule

// File: tb/tb_pattern_seq_detector.sv
// Directed and randomized checks of pattern_seq_detector against a queue-based model.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_pattern_seq_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inp = 1'b0;
  logic       vld = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] pat_in = 4'b0;
  logic       ovl = 1'b1;
  logic       clr = 1'b0;

  logic       out_a, armed_a, out_b, armed_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks = 0;
  int errors = 0;

  // reference model: valid bits since last reset/load/non-overlap match
  bit         mq[$];
  logic [3:0] mpat;
  logic       exp_out;
  int         exp_cnt_a, exp_cnt_b;

  always #5 clk = ~clk;

  pattern_seq_detector #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .CNT_W(8)) dut_a (
    .clk_i(clk), .reset_i(reset), .inp_i(inp), .inp_valid_i(vld), .load_i(ld),
    .pattern_in_i(pat_in), .overlap_i(ovl), .clear_count_i(clr),
    .out_o(out_a), .armed_o(armed_a), .match_count_o(cnt_a));

  pattern_seq_detector #(.PAT_W(4), .DEFAULT_PAT(4'b1011), .CNT_W(2)) dut_b (
    .clk_i(clk), .reset_i(reset), .inp_i(inp), .inp_valid_i(vld), .load_i(ld),
    .pattern_in_i(pat_in), .overlap_i(ovl), .clear_count_i(clr),
    .out_o(out_b), .armed_o(armed_b), .match_count_o(cnt_b));

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpat      = 4'b1011;
    exp_out   = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
  endtask

  task automatic model_update();
    bit m;
    m = 1'b0;
    if (ld) begin
      mpat = pat_in;
      mq.delete();
    end else if (vld) begin
      mq.push_back(inp);
      if (mq.size() > 4) void'(mq.pop_front());
      if (mq.size() == 4) begin
        m = 1'b1;
        for (int i = 0; i < 4; i++)
          if (mq[i] != mpat[3-i]) m = 1'b0;
      end
      if (m && !ovl) mq.delete();
    end
    exp_out = m;
    if (clr) begin
      exp_cnt_a = 0;
      exp_cnt_b = 0;
    end else if (m) begin
      if (exp_cnt_a < 255) exp_cnt_a++;
      if (exp_cnt_b < 3)   exp_cnt_b++;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".out_a"},   int'(out_a),   int'(exp_out));
    chk({tag, ".armed_a"}, int'(armed_a), int'(mq.size() == 4));
    chk({tag, ".cnt_a"},   int'(cnt_a),   exp_cnt_a);
    chk({tag, ".out_b"},   int'(out_b),   int'(exp_out));
    chk({tag, ".armed_b"}, int'(armed_b), int'(mq.size() == 4));
    chk({tag, ".cnt_b"},   int'(cnt_b),   exp_cnt_b);
  endtask

  task automatic step(string tag, bit b, bit v, bit l = 1'b0,
                      logic [3:0] p = 4'b0, bit c = 1'b0);
    @(negedge clk);
    inp = b; vld = v; ld = l; pat_in = p; clr = c;
    @(posedge clk);
    model_update();
    #1;
    check_all(tag);
  endtask

  // clear the counters and reload a pattern, leaving history empty
  task automatic restart(string tag, logic [3:0] p);
    step({tag, ".clr"}, 1'b0, 1'b0, 1'b0, 4'b0, 1'b1);
    step({tag, ".ld"},  1'b0, 1'b0, 1'b1, p,    1'b0);
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst.out", int'(out_a), 0);
    chk("rst.armed", int'(armed_a), 0);
    chk("rst.cnt", int'(cnt_a), 0);
    @(negedge clk);
    reset = 1'b0;

    // overlapping, default pattern 1011, stream 1011011
    ovl = 1'b1;
    step("ov.b1", 1, 1); step("ov.b2", 0, 1); step("ov.b3", 1, 1);
    step("ov.b4", 1, 1);
    chk("ov.pulse4", int'(out_a), 1);
    step("ov.b5", 0, 1); step("ov.b6", 1, 1); step("ov.b7", 1, 1);
    chk("ov.pulse7", int'(out_a), 1);
    chk("ov.count", int'(cnt_a), 2);

    // non-overlapping, same stream plus one bit
    ovl = 1'b0;
    restart("nov", 4'b1011);
    step("nov.b1", 1, 1); step("nov.b2", 0, 1); step("nov.b3", 1, 1);
    step("nov.b4", 1, 1);
    chk("nov.armed4", int'(armed_a), 0);
    step("nov.b5", 0, 1); step("nov.b6", 1, 1); step("nov.b7", 1, 1);
    chk("nov.out7", int'(out_a), 0);
    step("nov.b8", 0, 1);
    chk("nov.armed8", int'(armed_a), 1);
    chk("nov.count", int'(cnt_a), 1);

    // invalid cycles interleaved, inp toggling while invalid
    ovl = 1'b1;
    restart("iv", 4'b1011);
    step("iv.b1", 1, 1); step("iv.x1", 0, 0); step("iv.x1b", 1, 0);
    step("iv.b2", 0, 1); step("iv.x2", 1, 0); step("iv.x2b", 0, 0);
    step("iv.b3", 1, 1);
    step("iv.b4", 1, 1);
    chk("iv.pulse", int'(out_a), 1);
    chk("iv.count", int'(cnt_a), 1);

    // all-ones pattern, load with valid bit, counter saturation, clear vs match
    restart("ones", 4'b1011);
    step("ones.ld", 1, 1, 1'b1, 4'b1111);
    for (int i = 1; i <= 8; i++) step($sformatf("ones.b%0d", i), 1, 1);
    chk("ones.cnt_a", int'(cnt_a), 5);
    chk("ones.sat_b", int'(cnt_b), 3);
    step("ones.clr", 1, 1, 1'b0, 4'b0, 1'b1);
    chk("ones.clr_cnt", int'(cnt_b), 0);
    chk("ones.clr_out", int'(out_b), 1);

    // asynchronous reset mid-stream
    restart("ar", 4'b0110);
    step("ar.b1", 1, 1); step("ar.b2", 0, 1); step("ar.b3", 1, 1);
    step("ar.b4", 0, 1); step("ar.b5", 1, 1); step("ar.b6", 1, 1);
    #2;
    reset = 1'b1;
    vld = 1'b0;
    #1;
    chk("ar.out", int'(out_a), 0);
    chk("ar.armed", int'(armed_a), 0);
    chk("ar.cnt", int'(cnt_a), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step("ar.s1", 1, 1); step("ar.s2", 0, 1); step("ar.s3", 1, 1);
    chk("ar.nopulse", int'(out_a), 0);
    step("ar.s4", 1, 1);
    chk("ar.pulse", int'(out_a), 1);

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      ovl = ($urandom_range(0, 3) != 0);
      step("rnd", 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0),
           ($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
